fxp_accumulator: RTL and testbench
==================================

Name: fxp_accumulator

Overview:
- Sequential fixed-point accumulator for matrix-multiply dot products. Sums a stream of signed operands, each tagged with its own fractional width, into one result.
- Tracks the accumulator Q-format dynamically. On carry-out it widens the integer part instead of wrapping. Saturates only when no fractional bits are left to give up.
- Sits between the multiplier array and the result write-back; valid/ready on both sides.

Parameters:
- WIDTH, 16: data word width in bits; QI+QF == WIDTH at all times.
- QW, 4: width of the QI/QF format fields; requires 2**QW > WIDTH-1.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand present.
- in_ready  out  1  block accepts an operand this cycle.
- in_data  in  WIDTH  signed operand.
- in_qf  in  QW  fractional bits of in_data (0..WIDTH-1).
- in_last  in  1  operand is the final term of the current sum.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- out_data  out  WIDTH  signed result.
- out_qi  out  QW  integer bits of result, sign included (WIDTH-out_qf).
- out_qf  out  QW  fractional bits of result.
- out_sat  out  1  sticky: result was saturated at least once during this sum.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, out_qf=0, out_qi=WIDTH, out_sat=0. Internal acc=0, acc_qf=0. State=IDLE.
- States: IDLE -> ACC -> (NORM) -> OUT -> IDLE.
- IDLE:
  - in_ready=1.
  - On a transfer (in_valid&in_ready): acc=in_data, acc_qf=in_qf, sat=0.
  - If in_last: go to OUT (or NORM), else go to ACC.
- ACC: in_ready=1, one operand per cycle. Per transfer:
  - Align:
    - If in_qf > acc_qf: operand arithmetic-shifted right by (in_qf-acc_qf), truncating toward -inf.
    - If in_qf < acc_qf: acc arithmetic-shifted right by (acc_qf-in_qf), then acc_qf=in_qf.
  - Add at WIDTH+1 bits. Overflow means bit WIDTH differs from bit WIDTH-1.
  - On overflow with acc_qf>0: acc=sum[WIDTH:1], acc_qf-=1.
  - On overflow with acc_qf==0: acc=0x7F..F (positive) or 0x80..0 (negative), sat=1.
  - No overflow: acc=sum[WIDTH-1:0].
  - On in_last: go to OUT (or NORM).
- OUT:
  - out_valid=1; out_data, out_qf, out_qi and out_sat hold stable until out_valid&out_ready.
  - in_ready=0.
  - On handshake: go to IDLE and clear out_valid. A new sum may start the following cycle.
- Latency: out_valid rises 1 cycle after the in_last transfer (NORM disabled).
- Throughput: one operand per cycle; a single-term sum (in_last on the first operand) is legal.
- Simultaneous events:
  - in_valid while in OUT is ignored (in_ready=0).
  - rst has priority over every handshake.
- Reset mid-sum or mid-output discards the partial result; no out_valid pulse.
- in_qf > WIDTH-1: not checked; behaviour undefined.

Optional Feature:
- Macro: FXP_ACC_NORM_EN.
- Defined: after the last operand the block enters NORM before OUT.
  - Each NORM cycle: if acc[WIDTH-1]==acc[WIDTH-2] and acc_qf < WIDTH-1, then acc<<=1 and acc_qf+=1; otherwise go to OUT.
  - At most one bit per cycle, so up to WIDTH-1 extra cycles.
  - acc==0 normalizes to acc_qf=WIDTH-1.
  - in_ready=0 throughout NORM.
- Undefined: the NORM state does not exist and the result keeps the accumulated format.

Test Plan (WIDTH=16):
- Basic sum: 0x0100 qf8, then 0x0200 qf8 last -> out_data=0x0300, out_qf=8, out_qi=8, out_sat=0, out_valid 1 cycle after last.
- Overflow widening: 0x7000 qf8 + 0x7000 qf8 last -> 0x7000, qf7, qi9 (224.0); same with 0x9000+0x9000 -> 0x9000 qf7 (-224.0).
- Mixed-format alignment: 0x0100 qf8, then 0x0010 qf4 last -> 0x0020, qf4. Then 0x0010 qf4, then 0x0100 qf8 last -> 0x0020, qf4.
- Saturation: 0x7FFF qf0 + 0x0001 qf0 last -> 0x7FFF, out_sat=1. Next sum 0x0001 qf0 last -> out_sat=0.
- Backpressure and reset: hold out_ready=0 for 5 cycles -> output stable and in_ready=0; assert rst during ACC -> no out_valid, all reset values next cycle.
- FXP_ACC_NORM_EN: 0x0003 qf8 last -> after 7 NORM cycles out_data=0x0180, out_qf=15, out_qi=1; 0x0000 -> out_qf=15.

Source files
------------

// File: rtl/fxp_accumulator.sv
// Streaming signed fixed-point accumulator with a dynamic Q-format that widens the integer part on overflow.
// Optional macro FXP_ACC_NORM_EN adds a post-sum NORM state that left-normalizes the result.
module fxp_accumulator #(
    parameter int WIDTH = 16,
    parameter int QW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [QW-1:0]    in_qf,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [QW-1:0]    out_qi,
    output logic [QW-1:0]    out_qf,
    output logic             out_sat
);

    // out_qi is QW bits wide, so a qf of 0 reports WIDTH modulo 2**QW.
    localparam logic [QW-1:0] WIDTH_LO = WIDTH[QW-1:0];

`ifdef FXP_ACC_NORM_EN
    localparam int            QF_MAX_I = WIDTH - 1;
    localparam logic [QW-1:0] QF_MAX   = QF_MAX_I[QW-1:0];

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_NORM, S_OUT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;
`endif

    state_t                  state;
    logic signed [WIDTH-1:0] acc;
    logic [QW-1:0]           acc_qf;
    logic                    sat;

    logic signed [WIDTH-1:0] acc_al;
    logic signed [WIDTH-1:0] op_al;
    logic [WIDTH:0]          sum;
    logic [QW-1:0]           sum_qf;
    logic signed [WIDTH-1:0] fin_acc;
    logic [QW-1:0]           fin_qf;
    logic                    fin_sat;
    logic                    xfer;

    assign xfer = in_valid & in_ready;

    // Align both terms to the smaller fractional width, add one bit wide, then widen or saturate.
    always_comb begin
        acc_al = acc;
        op_al  = $signed(in_data);
        sum_qf = acc_qf;
        if (in_qf > acc_qf) begin
            op_al = $signed(in_data) >>> (in_qf - acc_qf);
        end else if (in_qf < acc_qf) begin
            acc_al = acc >>> (acc_qf - in_qf);
            sum_qf = in_qf;
        end
        sum     = {acc_al[WIDTH-1], acc_al} + {op_al[WIDTH-1], op_al};
        fin_acc = sum[WIDTH-1:0];
        fin_qf  = sum_qf;
        fin_sat = sat;
        if (sum[WIDTH] != sum[WIDTH-1]) begin
            if (sum_qf != '0) begin
                fin_acc = sum[WIDTH:1];
                fin_qf  = sum_qf - 1'b1;
            end else begin
                fin_acc = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                fin_sat = 1'b1;
            end
        end
        if (state == S_IDLE) begin
            fin_acc = $signed(in_data);
            fin_qf  = in_qf;
            fin_sat = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            acc       <= '0;
            acc_qf    <= '0;
            sat       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_qf    <= '0;
            out_qi    <= WIDTH_LO;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_ACC: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        acc    <= fin_acc;
                        acc_qf <= fin_qf;
                        sat    <= fin_sat;
                        if (in_last) begin
                            in_ready <= 1'b0;
`ifdef FXP_ACC_NORM_EN
                            state    <= S_NORM;
`else
                            state     <= S_OUT;
                            out_valid <= 1'b1;
                            out_data  <= fin_acc;
                            out_qf    <= fin_qf;
                            out_qi    <= WIDTH_LO - fin_qf;
                            out_sat   <= fin_sat;
`endif
                        end else begin
                            state <= S_ACC;
                        end
                    end
                end
`ifdef FXP_ACC_NORM_EN
                S_NORM: begin
                    if ((acc[WIDTH-1] == acc[WIDTH-2]) && (acc_qf < QF_MAX)) begin
                        acc    <= acc <<< 1;
                        acc_qf <= acc_qf + 1'b1;
                    end else begin
                        state     <= S_OUT;
                        out_valid <= 1'b1;
                        out_data  <= acc;
                        out_qf    <= acc_qf;
                        out_qi    <= WIDTH_LO - acc_qf;
                        out_sat   <= sat;
                    end
                end
`endif
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fxp_accumulator.sv
// Self-checking bench for fxp_accumulator: directed cases plus random sums against an integer-valued reference model.
// Follows FXP_ACC_NORM_EN the same way as the design.
module tb_fxp_accumulator;

    localparam int WIDTH = 16;
    localparam int QW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [QW-1:0]    in_qf;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [QW-1:0]    out_qi;
    logic [QW-1:0]    out_qf;
    logic             out_sat;

    int   errors = 0;
    int   checks = 0;
    int   m_acc;
    int   m_qf;
    logic m_sat;

    fxp_accumulator #(.WIDTH(WIDTH), .QW(QW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_qf     (in_qf),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_qi    (out_qi),
        .out_qf    (out_qf),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    function automatic int floorDiv(int v, int d);
        int q;
        q = v / d;
        if ((v % d) != 0 && v < 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [31:0] expQi(int qf);
        return 32'((WIDTH - qf) % (1 << QW));
    endfunction

    task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: real-valued sum = m_acc * 2**-m_qf, kept in plain integers.
    task automatic modelOp(logic [WIDTH-1:0] d, logic [QW-1:0] q, bit first);
        int a;
        int b;
        int s;
        int qi;
        b  = $signed(d);
        qi = int'(q);
        if (first) begin
            m_acc = b;
            m_qf  = qi;
            m_sat = 1'b0;
        end else begin
            a = m_acc;
            if (qi > m_qf) begin
                b = floorDiv(b, 1 << (qi - m_qf));
            end else if (qi < m_qf) begin
                a    = floorDiv(a, 1 << (m_qf - qi));
                m_qf = qi;
            end
            s = a + b;
            if (s > (1 << (WIDTH-1)) - 1 || s < -(1 << (WIDTH-1))) begin
                if (m_qf > 0) begin
                    m_acc = floorDiv(s, 2);
                    m_qf  = m_qf - 1;
                end else begin
                    m_acc = (s > 0) ? (1 << (WIDTH-1)) - 1 : -(1 << (WIDTH-1));
                    m_sat = 1'b1;
                end
            end else begin
                m_acc = s;
            end
        end
    endtask

    task automatic modelNorm();
        while (m_qf < WIDTH-1 && m_acc >= -(1 << (WIDTH-2)) && m_acc < (1 << (WIDTH-2))) begin
            m_acc = m_acc * 2;
            m_qf  = m_qf + 1;
        end
    endtask

    task automatic applyStimulus(logic [WIDTH-1:0] d, logic [QW-1:0] q, bit last, bit first);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_qf    = q;
        in_last  = last;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("in_ready_wait", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        modelOp(d, q, first);
        if (last) begin
            checkOutput("in_ready_after_last", in_ready, 0);
`ifdef FXP_ACC_NORM_EN
            modelNorm();
            checkOutput("norm_not_valid", out_valid, 0);
`else
            checkOutput("latency_valid", out_valid, 1);
`endif
        end else begin
            checkOutput("in_ready_acc", in_ready, 1);
        end
    endtask

    task automatic waitValid(string tag);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({tag, "_valid"}, out_valid, 1);
    endtask

    task automatic expectConst(string tag, logic [31:0] d, int qf, logic [31:0] s);
        waitValid(tag);
        checkOutput({tag, "_cdata"}, out_data, d);
        checkOutput({tag, "_cqf"}, out_qf, 32'(qf));
        checkOutput({tag, "_cqi"}, out_qi, expQi(qf));
        checkOutput({tag, "_csat"}, out_sat, s);
    endtask

    task automatic getResult(string tag, int hold);
        waitValid(tag);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        checkOutput({tag, "_data"}, out_data, 32'(m_acc) & 32'hFFFF);
        checkOutput({tag, "_qf"}, out_qf, 32'(m_qf));
        checkOutput({tag, "_qi"}, out_qi, expQi(m_qf));
        checkOutput({tag, "_sat"}, out_sat, 32'(m_sat));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, "_done"}, out_valid, 0);
    endtask

    task automatic checkResetValues(string tag);
        checkOutput({tag, "_in_ready"}, in_ready, 0);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_out_data"}, out_data, 0);
        checkOutput({tag, "_out_qf"}, out_qf, 0);
        checkOutput({tag, "_out_qi"}, out_qi, expQi(0));
        checkOutput({tag, "_out_sat"}, out_sat, 0);
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_qf     = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst = 1'b0;

        applyStimulus(16'h0100, 4'd8, 1'b0, 1'b1);
        applyStimulus(16'h0200, 4'd8, 1'b1, 1'b0);
`ifndef FXP_ACC_NORM_EN
        expectConst("basic", 32'h0300, 8, 0);
`endif
        getResult("basic", 0);

        applyStimulus(16'h7000, 4'd8, 1'b0, 1'b1);
        applyStimulus(16'h7000, 4'd8, 1'b1, 1'b0);
`ifndef FXP_ACC_NORM_EN
        expectConst("widen_pos", 32'h7000, 7, 0);
`endif
        getResult("widen_pos", 0);

        applyStimulus(16'h9000, 4'd8, 1'b0, 1'b1);
        applyStimulus(16'h9000, 4'd8, 1'b1, 1'b0);
`ifndef FXP_ACC_NORM_EN
        expectConst("widen_neg", 32'h9000, 7, 0);
`endif
        getResult("widen_neg", 0);

        applyStimulus(16'h0100, 4'd8, 1'b0, 1'b1);
        applyStimulus(16'h0010, 4'd4, 1'b1, 1'b0);
`ifndef FXP_ACC_NORM_EN
        expectConst("mixed_a", 32'h0020, 4, 0);
`endif
        getResult("mixed_a", 0);

        applyStimulus(16'h0010, 4'd4, 1'b0, 1'b1);
        applyStimulus(16'h0100, 4'd8, 1'b1, 1'b0);
`ifndef FXP_ACC_NORM_EN
        expectConst("mixed_b", 32'h0020, 4, 0);
`endif
        getResult("mixed_b", 0);

        applyStimulus(16'h7FFF, 4'd0, 1'b0, 1'b1);
        applyStimulus(16'h0001, 4'd0, 1'b1, 1'b0);
        expectConst("sat", 32'h7FFF, 0, 1);
        getResult("sat", 0);

        applyStimulus(16'h0001, 4'd0, 1'b1, 1'b1);
        getResult("sat_clear", 0);

        // Operands offered while the result is held must be ignored.
        applyStimulus(16'h0100, 4'd8, 1'b0, 1'b1);
        applyStimulus(16'h0010, 4'd4, 1'b1, 1'b0);
        waitValid("bp");
        held     = out_data;
        in_valid = 1'b1;
        in_data  = 16'h5555;
        in_qf    = 4'd2;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("bp_hold_valid", out_valid, 1);
            checkOutput("bp_in_ready", in_ready, 0);
            checkOutput("bp_stable", out_data, 32'(held));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        getResult("bp", 0);

        applyStimulus(16'h1234, 4'd4, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        checkResetValues("mid_rst");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("mid_rst_no_valid", out_valid, 0);
        end
        applyStimulus(16'h0100, 4'd8, 1'b1, 1'b1);
        getResult("after_rst", 0);

        applyStimulus(16'h0003, 4'd8, 1'b1, 1'b1);
`ifdef FXP_ACC_NORM_EN
        expectConst("norm3", 32'h0180, 15, 0);
`endif
        getResult("norm3", 0);

        applyStimulus(16'h0000, 4'd3, 1'b1, 1'b1);
`ifdef FXP_ACC_NORM_EN
        expectConst("norm0", 32'h0000, 15, 0);
`endif
        getResult("norm0", 0);

        for (int t = 0; t < 25; t++) begin
            int nops;
            nops = $urandom_range(1, 6);
            for (int k = 0; k < nops; k++) begin
                applyStimulus(16'($urandom), 4'($urandom_range(0, 15)), k == nops - 1, k == 0);
            end
            getResult("rand", $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
